if_stage: RTL

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the decode-stage controller. It owns the PC, presents the fetch address to a combinational instruction memory, and latches {pc, instruction, valid} into IF/ID. It handles load-use stalls, EX-stage redirects (taken branch, JAL, JALR) and the sticky halt raised when decode sees opcode 7'b0000000.

---
 rtl/if_stage_pkg.sv | 32 +++
 rtl/ifid_reg.sv | 38 +++
 rtl/if_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Types and constants shared by the fetch stage and the decode-stage controller.
package if_stage_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] LW      = 7'b0000011;
  localparam logic [6:0] SW      = 7'b0100011;
  localparam logic [6:0] BR      = 7'b1100011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] HALT_OP = 7'b0000000;

  // Bubble instruction. It is addi x0,x0,0 and not zero, because decode treats opcode 0 as halt.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Action taken by the fetch stage on the next edge, listed highest priority first.
  typedef enum logic [2:0] {
    ACT_FROZEN,
    ACT_REDIRECT,
    ACT_HALT,
    ACT_STALL,
    ACT_FETCH
  } fetch_act_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Hold keeps every field, and hold wins over flush.
// Flush loads a NOP bubble that is tagged with the supplied PC.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic [PC_W-1:0]  pc_d,
  input  logic [INS_W-1:0] instr_d,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [INS_W-1:0] ifid_instr,
  output logic             ifid_valid
);

  // NOTE: sequential state uses non-blocking assignments, so that every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc    <= '0;
      ifid_instr <= INS_W'(NOP_INSTR);
      ifid_valid <= 1'b0;
    end else if (!hold) begin
      ifid_pc <= pc_d;
      if (flush) begin
        ifid_instr <= INS_W'(NOP_INSTR);
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= instr_d;
        ifid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. It owns the PC, handles stall, redirect and sticky halt,
// and feeds the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  input  logic             halt_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]  ifid_pc_o,
  output logic [INS_W-1:0] ifid_instr_o,
  output logic             ifid_valid_o,
  output logic             halted_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_d;
  logic            hold, flush;
  fetch_act_e      act;

  // A halt seen on a bubble is not a real instruction and is ignored.
  logic halt_q;
  assign halt_q = halt_i & ifid_valid_o;

  always_comb begin
    if (halted_o)        act = ACT_FROZEN;
    else if (redirect_i) act = ACT_REDIRECT;
    else if (halt_q)     act = ACT_HALT;
    else if (stall_i)    act = ACT_STALL;
    else                 act = ACT_FETCH;
  end

  // NOTE: each output gets a default first, so that no path through the case infers a latch.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_o;
    hold     = 1'b0;
    flush    = 1'b0;
    unique case (act)
      ACT_FROZEN,
      ACT_STALL:    hold = 1'b1;
      ACT_REDIRECT: begin
        pc_d  = redirect_pc_i & ~PC_W'(3);
        flush = 1'b1;
      end
      ACT_HALT: begin
        halted_d = 1'b1;
        flush    = 1'b1;
      end
      default:      pc_d = pc_q + PC_W'(PC_INC);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      halted_o <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_o <= halted_d;
    end
  end

  assign imem_addr_o = pc_q;

  ifid_reg #(.PC_W(PC_W), .INS_W(INS_W)) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .pc_d       (pc_q),
    .instr_d    (imem_rdata_i),
    .ifid_pc    (ifid_pc_o),
    .ifid_instr (ifid_instr_o),
    .ifid_valid (ifid_valid_o)
  );

endmodule
